ram_read: RTL and testbench

- Read-side counterpart of the ram_use writer FSM: drains entries the writer stored in the shared buffer RAM and presents them one per beat on a valid/ready output.
- Sits between the buffer RAM read port and the downstream consumer.
- Exposes state/nextstate in the same 2-bit encoding style as the writer, for debug and bench probing.

---
 rtl/ram_read.sv | 163 ++++++++++++++++
 tb/tb_ram_read.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read.sv
// Drains wr_count entries from the shared buffer RAM and emits them one beat at a time on a valid/ready output.
// Latency: 3 edges from start to the first out_valid, then 3 cycles per beat while out_ready stays high.
// Backpressure: out_ready=0 holds out_data/out_valid stable and issues no further RAM reads until the beat is taken.
module ram_read #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   wr_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              underflow,
    output logic [1:0]        state,
    output logic [1:0]        nextstate
);

    // Same 2-bit encoding style as the writer FSM so both can be probed side by side.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        OUTPUT = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t cur_st;
    state_t nxt_st;

    // ptr/len are one bit wider than the address so a full buffer (DEPTH entries) is representable.
    logic [ADDR_W:0] ptr;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] ptr_inc;
    logic            pend;

    logic            start_ok;
    logic            start_empty;
    logic            beat_xfer;
    logic            last_beat;

    assign state     = cur_st;
    assign nextstate = nxt_st;

    assign ptr_inc     = ptr + {{ADDR_W{1'b0}}, 1'b1};
    assign last_beat   = (ptr_inc == len);
    assign start_ok    = (cur_st == IDLE) && start && (wr_count != '0);
    assign start_empty = (cur_st == IDLE) && start && (wr_count == '0);
    // A beat is only taken once the captured data is on the bus; the capture cycle itself ignores out_ready.
    assign beat_xfer   = (cur_st == OUTPUT) && !pend && out_valid && out_ready;

    // Next-state function; abort overrides every other transition.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE: begin
                if (start_ok) begin
                    nxt_st = FETCH;
                end
            end
            FETCH: begin
                nxt_st = OUTPUT;
            end
            OUTPUT: begin
                if (beat_xfer) begin
                    nxt_st = last_beat ? DONE : FETCH;
                end
            end
            DONE: begin
                nxt_st = IDLE;
            end
            default: begin
                nxt_st = IDLE;
            end
        endcase
        if (abort) begin
            nxt_st = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Drain pointer and frozen length; wr_count is only looked at on the accepting start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            len <= '0;
        end else if (abort) begin
            ptr <= '0;
        end else if (start_ok) begin
            ptr <= '0;
            len <= wr_count;
        end else if (beat_xfer) begin
            ptr <= ptr_inc;
        end
    end

    // pend marks the cycle in which the RAM's registered read data becomes valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
        end else if (abort) begin
            pend <= 1'b0;
        end else if (cur_st == FETCH) begin
            pend <= 1'b1;
        end else if (cur_st == OUTPUT) begin
            pend <= 1'b0;
        end
    end

    // Read strobe is high for exactly the FETCH cycle; the address is set up on entry and then held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= (nxt_st == FETCH);
            if (nxt_st == FETCH) begin
                // Low address bits only: entry DEPTH-1 is the last read, never a wrap back to 0.
                rd_addr <= (cur_st == IDLE) ? '0 : ptr_inc[ADDR_W-1:0];
            end
        end
    end

    // Output beat register: capture on the pend cycle, drop valid on handshake or abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
        end else if ((cur_st == OUTPUT) && pend) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
        end else if (beat_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Single-cycle status pulses: done for the DONE cycle, underflow for an empty start request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            done      <= (cur_st == OUTPUT) && (nxt_st == DONE);
            underflow <= start_empty && !abort;
        end
    end

endmodule

// File: tb/tb_ram_read.sv
module tb_ram_read;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   wr_count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              done;
    logic              underflow;
    logic [1:0]        state;
    logic [1:0]        nextstate;

    logic [DATA_W-1:0] mem [16];
    int                rd_count = 0;
    int                n_total  = 0;
    int                n_pass   = 0;
    int                rd_before;
    logic [7:0]        exp3 [3];

    ram_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .wr_count  (wr_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .underflow (underflow),
        .state     (state),
        .nextstate (nextstate)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer RAM model plus a count of issued reads.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= mem[rd_addr];
            rd_count <= rd_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bounded wait for IDLE; an expired budget is counted as a failed check.
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (state !== 2'b00 && n < budget) begin
            step();
            n++;
        end
        chk(tag, state, 32'h0);
    endtask

    initial begin
        exp3[0] = 8'hA1;
        exp3[1] = 8'hB2;
        exp3[2] = 8'hC3;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA1;
        mem[1] = 8'hB2;
        mem[2] = 8'hC3;

        rst = 1'b0; start = 1'b0; abort = 1'b0; wr_count = '0; out_ready = 1'b0;
        #2;
        chk("rst_state", state, 32'h0);
        chk("rst_rd_en", rd_en, 32'h0);
        chk("rst_valid", out_valid, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_uflow", underflow, 32'h0);
        step();
        rst = 1'b1;
        step();

        // Normal drain of three entries; wr_count changes after start must be ignored.
        wr_count = 5'd3; start = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            step();
            start = 1'b0;
            wr_count = 5'd1;
            chk("nd_fetch_st", state, 32'h1);
            chk("nd_rd_en", rd_en, 32'h1);
            chk("nd_rd_addr", rd_addr, b);
            step();
            chk("nd_out_st", state, 32'h2);
            chk("nd_pend_nv", out_valid, 32'h0);
            step();
            chk("nd_valid", out_valid, 32'h1);
            chk("nd_data", out_data, exp3[b]);
            chk("nd_no_done", done, 32'h0);
        end
        step();
        chk("nd_done_st", state, 32'h3);
        chk("nd_done", done, 32'h1);
        chk("nd_done_nv", out_valid, 32'h0);
        step();
        chk("nd_idle", state, 32'h0);
        chk("nd_done_off", done, 32'h0);

        // Backpressure on the first of two beats.
        wr_count = 5'd2; start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        chk("bp_valid0", out_valid, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_v", out_valid, 32'h1);
            chk("bp_hold_d", out_data, 32'hA1);
            chk("bp_no_rd", rd_en, 32'h0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_fetch2", rd_en, 32'h1);
        chk("bp_addr2", rd_addr, 32'h1);
        step();
        step();
        chk("bp_data2", out_data, 32'hB2);
        step();
        chk("bp_done", done, 32'h1);
        step();
        chk("bp_idle", state, 32'h0);

        // Empty start: one-cycle underflow pulse, no read.
        rd_before = rd_count;
        wr_count = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("em_uflow", underflow, 32'h1);
        chk("em_state", state, 32'h0);
        chk("em_rd_en", rd_en, 32'h0);
        step();
        chk("em_uflow_off", underflow, 32'h0);
        chk("em_no_reads", rd_count - rd_before, 32'h0);

        // Abort together with start in IDLE: abort wins, no underflow.
        abort = 1'b1; start = 1'b1;
        step();
        chk("as_state", state, 32'h0);
        chk("as_uflow", underflow, 32'h0);
        abort = 1'b0; start = 1'b0;

        // Full buffer of 16 entries.
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        rd_before = rd_count;
        wr_count = 5'd16; start = 1'b1; out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            step();
            start = 1'b0;
            chk("fu_rd_addr", rd_addr, b);
            step();
            step();
            chk("fu_data", out_data, b);
        end
        step();
        chk("fu_done", done, 32'h1);
        chk("fu_rd_en", rd_en, 32'h0);
        step();
        chk("fu_idle", state, 32'h0);
        step();
        chk("fu_reads", rd_count - rd_before, 32'd16);

        // Abort during the second of three beats, then a fresh drain replays from address 0.
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
        wr_count = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("ab_beat0", out_data, 32'hA1);
        step();
        chk("ab_fetch1", rd_addr, 32'h1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_state", state, 32'h0);
        chk("ab_valid", out_valid, 32'h0);
        chk("ab_rd_en", rd_en, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab_no_done", done, 32'h0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ab_re_addr", rd_addr, 32'h0);
        step();
        step();
        chk("ab_re_data", out_data, 32'hA1);
        wait_idle("ab_finish", 40);

        // Asynchronous reset in the middle of FETCH.
        wr_count = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("ar_in_fetch", state, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_state", state, 32'h0);
        chk("ar_rd_en", rd_en, 32'h0);
        chk("ar_valid", out_valid, 32'h0);
        chk("ar_done", done, 32'h0);
        rst = 1'b1;
        step();
        chk("ar_stay_idle", state, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
